ll_reservation_unit: RTL and testbench
======================================

Name: ll_reservation_unit

Overview:
- Multi-thread successor to the single LLbit register: one link reservation per hardware thread for MIPS LL/SC atomics.
- Each entry holds a valid bit, a granule-aligned link address and an optional expiry counter.
- Sits beside the MEM stage.
  - LL sets a reservation.
  - SC queries and consumes it.
  - Stores, exceptions/ERET and timeouts clear it.
  - CP0 can read the LLbit and LLAddr state of any thread.

Parameters:
- NUM_THREADS, 2: number of reservation entries; legal range 1..16.
- ADDR_W, 32: physical address width.
- GRAN_LOG2, 2: log2 of the reservation granule in bytes. Address bits [GRAN_LOG2-1:0] are ignored on compare and stored as zero.
- TIMEOUT, 0: cycles after which an untouched reservation expires. 0 disables the expiry counter entirely.
- TID_W, derived: max(1, clog2(NUM_THREADS)).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ll_valid  in  1  LL executes this cycle
- ll_tid  in  TID_W  thread issuing the LL
- ll_addr  in  ADDR_W  LL physical address
- sc_valid  in  1  SC executes this cycle
- sc_tid  in  TID_W  thread issuing the SC
- sc_addr  in  ADDR_W  SC physical address
- sc_success  out  1  combinational SC result for the current cycle
- st_valid  in  1  ordinary store, or external coherent write, this cycle
- st_addr  in  ADDR_W  store physical address
- clr_vec  in  NUM_THREADS  per-thread clear (exception entry, ERET)
- rd_tid  in  TID_W  CP0 read select
- rd_llbit  out  1  valid bit of entry rd_tid, combinational
- rd_lladdr  out  ADDR_W  stored link address of entry rd_tid, combinational
- resv_vec  out  NUM_THREADS  valid bit of every entry, registered state

Behaviour:
- Reset (rst_n low, asynchronous):
  - all valid bits cleared, all addresses zeroed, all counters zeroed;
  - consequently sc_success=0, rd_llbit=0, rd_lladdr=0, resv_vec=0.
  - Reset asserted mid-sequence discards every reservation; the first edge after release obeys the normal rules.
- Granule match: (a >> GRAN_LOG2) == (b >> GRAN_LOG2).
- sc_success = sc_valid & valid[sc_tid] & match(addr[sc_tid], sc_addr).
  - Zero latency; it reflects state before this cycle's edge.
  - A same-cycle LL never makes an SC succeed.
- Per-entry next state at each rising edge, in priority order (highest first):
  1. clr_vec[i]=1 -> valid cleared.
  2. sc_valid & sc_tid==i -> valid cleared, whether the SC succeeds or fails.
  3. sc_success & sc_tid!=i & match(addr[i], sc_addr) -> valid cleared (the successful SC's store breaks other links).
  4. st_valid & match(addr[i], st_addr) -> valid cleared. This applies to every thread, including the storing one.
  5. ll_valid & ll_tid==i -> valid=1, addr=ll_addr with low GRAN_LOG2 bits zeroed, counter=0. A re-LL overwrites the existing address.
  6. TIMEOUT>0 & valid & counter==TIMEOUT-1 -> valid cleared.
  7. Otherwise, when TIMEOUT>0 and valid, the counter increments. The counter saturates and never wraps.
- Clears beat sets: an LL in the same cycle as a matching store, SC or clear leaves the entry invalid, and the software retry loop handles it.
- Address field:
  - retained when valid clears, so CP0 LLAddr reads the last link address;
  - only rule 5 or reset changes it.
- tid inputs at or above NUM_THREADS:
  - the LL is ignored;
  - the SC returns failure and clears nothing;
  - rd returns zeros.
- ll_valid and sc_valid both high in the same cycle are illegal; a bench assertion flags them, and RTL behaviour then follows the priority order above.
- resv_vec is the registered valid bits, with no combinational path from any input.

Decomposition:
- Package mips_ll_pkg:
  - function for granule compare;
  - localparam TID_W computation helper;
  - clog2 helper.
- Sub-module ll_resv_entry, instantiated NUM_THREADS times in a generate loop:
  - holds valid, addr and counter;
  - takes decoded per-entry set/clear strobes;
  - provides the match output against the sc_addr and st_addr buses.
- Top level:
  - decodes tids;
  - muxes the sc_success and rd outputs;
  - computes the cross-thread SC clear.

Test Plan:
- Reset, then LL tid0 addr 0x1000_0004, next cycle SC tid0 addr 0x1000_0004 -> sc_success=1. Entry 0 is then cleared, and a second SC returns 0.
- GRAN_LOG2=2: LL tid1 at 0x2000_0008, SC tid1 at 0x2000_000B -> success=1. With 0x2000_000C instead -> success=0. rd_lladdr=0x2000_0008 throughout.
- Two threads linked to 0x3000_0000:
  - tid0 SC succeeds -> resv_vec goes 2'b11 -> 2'b00;
  - tid1's later SC -> success=0.
- LL tid0 0x4000_0010 with st_valid 0x4000_0010 in the same cycle -> resv_vec[0]=0 and SC fails. A store to 0x4000_0020 instead -> the reservation survives.
- TIMEOUT=8: LL, then idle 7 cycles -> rd_llbit=1; at the 8th edge -> rd_llbit=0, and SC fails.
- clr_vec=2'b10 while both threads are valid -> only entry 1 clears. Then assert rst_n low asynchronously mid-cycle -> resv_vec=0 immediately, rd_lladdr=0.

Source files
------------

// File: rtl/mips_ll_pkg.sv
// Shared helpers for the LL/SC reservation unit: width derivation and granule compare.
package mips_ll_pkg;

    localparam int MAX_ADDR_W = 64;

    function automatic int clog2Fn(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int tidWidth(input int numThreads);
        return (clog2Fn(numThreads) < 1) ? 1 : clog2Fn(numThreads);
    endfunction

    // Callers zero-extend both addresses to MAX_ADDR_W before comparing.
    function automatic logic granMatch(input logic [MAX_ADDR_W-1:0] a,
                                       input logic [MAX_ADDR_W-1:0] b,
                                       input int granLog2);
        return (a >> granLog2) == (b >> granLog2);
    endfunction

endpackage

// File: rtl/ll_resv_entry.sv
// One thread's link reservation: valid bit, granule-aligned address and optional expiry counter.
module ll_resv_entry
    import mips_ll_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int GRAN_LOG2 = 2,
    parameter int TIMEOUT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              setStb,
    input  logic              clrStb,
    input  logic [ADDR_W-1:0] setAddr,
    input  logic [ADDR_W-1:0] scAddr,
    input  logic [ADDR_W-1:0] stAddr,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic              scMatch,
    output logic              stMatch
);

    localparam int CNT_W = (clog2Fn(TIMEOUT + 1) < 1) ? 1 : clog2Fn(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    assign scMatch = granMatch(MAX_ADDR_W'(addr), MAX_ADDR_W'(scAddr), GRAN_LOG2);
    assign stMatch = granMatch(MAX_ADDR_W'(addr), MAX_ADDR_W'(stAddr), GRAN_LOG2);

    // Clears always win over a same-cycle set; the address only moves on a set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            cnt   <= '0;
        end else if (clrStb) begin
            valid <= 1'b0;
        end else if (setStb) begin
            valid <= 1'b1;
            addr  <= (setAddr >> GRAN_LOG2) << GRAN_LOG2;
            cnt   <= '0;
        end else if (TIMEOUT > 0 && valid) begin
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
                valid <= 1'b0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ll_reservation_unit.sv
// Per-thread LL/SC link reservations beside the MEM stage, with CP0 LLbit/LLAddr readback.
module ll_reservation_unit
    import mips_ll_pkg::*;
#(
    parameter int NUM_THREADS = 2,
    parameter int ADDR_W      = 32,
    parameter int GRAN_LOG2   = 2,
    parameter int TIMEOUT     = 0,
    localparam int TID_W      = tidWidth(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ll_valid,
    input  logic [TID_W-1:0]       ll_tid,
    input  logic [ADDR_W-1:0]      ll_addr,
    input  logic                   sc_valid,
    input  logic [TID_W-1:0]       sc_tid,
    input  logic [ADDR_W-1:0]      sc_addr,
    output logic                   sc_success,
    input  logic                   st_valid,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [NUM_THREADS-1:0] clr_vec,
    input  logic [TID_W-1:0]       rd_tid,
    output logic                   rd_llbit,
    output logic [ADDR_W-1:0]      rd_lladdr,
    output logic [NUM_THREADS-1:0] resv_vec
);

    // ll/sc/st valid are single-cycle strobes sampled at every rising edge; there is
    // no ready, the unit accepts an operation every cycle.

    logic [NUM_THREADS-1:0] valid;
    logic [NUM_THREADS-1:0] scMatch;
    logic [NUM_THREADS-1:0] stMatch;
    logic [NUM_THREADS-1:0] llHit;
    logic [NUM_THREADS-1:0] scHit;
    logic [NUM_THREADS-1:0] clrStb;
    logic [ADDR_W-1:0]      addr [NUM_THREADS];
    logic                   llScMatch;
    logic                   llStMatch;

    // An incoming LL address is also checked so that a same-cycle breaking write wins.
    assign llScMatch = granMatch(MAX_ADDR_W'(ll_addr), MAX_ADDR_W'(sc_addr), GRAN_LOG2);
    assign llStMatch = granMatch(MAX_ADDR_W'(ll_addr), MAX_ADDR_W'(st_addr), GRAN_LOG2);

    always_comb begin
        llHit      = '0;
        scHit      = '0;
        sc_success = 1'b0;
        rd_llbit   = 1'b0;
        rd_lladdr  = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            llHit[i] = ll_valid && (ll_tid == TID_W'(i));
            scHit[i] = sc_valid && (sc_tid == TID_W'(i));
            if (scHit[i]) begin
                sc_success = valid[i] & scMatch[i];
            end
            if (rd_tid == TID_W'(i)) begin
                rd_llbit  = valid[i];
                rd_lladdr = addr[i];
            end
        end
    end

    always_comb begin
        clrStb = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            clrStb[i] = clr_vec[i]
                      | scHit[i]
                      | (sc_success & ~scHit[i] & (scMatch[i] | (llHit[i] & llScMatch)))
                      | (st_valid & (stMatch[i] | (llHit[i] & llStMatch)));
        end
    end

    for (genvar g = 0; g < NUM_THREADS; g++) begin : gEntry
        ll_resv_entry #(
            .ADDR_W    (ADDR_W),
            .GRAN_LOG2 (GRAN_LOG2),
            .TIMEOUT   (TIMEOUT)
        ) uEntry (
            .clk     (clk),
            .rst_n   (rst_n),
            .setStb  (llHit[g]),
            .clrStb  (clrStb[g]),
            .setAddr (ll_addr),
            .scAddr  (sc_addr),
            .stAddr  (st_addr),
            .valid   (valid[g]),
            .addr    (addr[g]),
            .scMatch (scMatch[g]),
            .stMatch (stMatch[g])
        );
    end

    assign resv_vec = valid;

endmodule

// File: tb/tb_ll_reservation_unit.sv
// Directed bench for ll_reservation_unit: drivers push expected results, a negedge monitor checks them.
module tb_ll_reservation_unit;

    localparam int NT = 2;
    localparam int AW = 32;
    localparam int GL = 2;
    localparam int TO = 8;
    localparam int TW = 1;
    localparam int SW = 1 + AW + NT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ll_valid;
    logic [TW-1:0] ll_tid;
    logic [AW-1:0] ll_addr;
    logic          sc_valid;
    logic [TW-1:0] sc_tid;
    logic [AW-1:0] sc_addr;
    logic          sc_success;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [NT-1:0] clr_vec;
    logic [TW-1:0] rd_tid;
    logic          rd_llbit;
    logic [AW-1:0] rd_lladdr;
    logic [NT-1:0] resv_vec;
    logic          chk_stb;

    logic [0:0]    exp_q[$];
    logic [SW-1:0] state_q[$];
    int            total = 0;
    int            bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    ll_reservation_unit #(
        .NUM_THREADS (NT),
        .ADDR_W      (AW),
        .GRAN_LOG2   (GL),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ll_valid   (ll_valid),
        .ll_tid     (ll_tid),
        .ll_addr    (ll_addr),
        .sc_valid   (sc_valid),
        .sc_tid     (sc_tid),
        .sc_addr    (sc_addr),
        .sc_success (sc_success),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .clr_vec    (clr_vec),
        .rd_tid     (rd_tid),
        .rd_llbit   (rd_llbit),
        .rd_lladdr  (rd_lladdr),
        .resv_vec   (resv_vec)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(ll_valid && sc_valid)) else $error("ll_valid and sc_valid both high");
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic idle();
        ll_valid = 1'b0; ll_tid = '0; ll_addr = '0;
        sc_valid = 1'b0; sc_tid = '0; sc_addr = '0;
        st_valid = 1'b0; st_addr = '0;
        clr_vec  = '0;   chk_stb = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_ll(input logic [TW-1:0] tid, input logic [AW-1:0] a);
        ll_valid = 1'b1; ll_tid = tid; ll_addr = a;
    endtask

    task automatic do_ll(input logic [TW-1:0] tid, input logic [AW-1:0] a);
        set_ll(tid, a);
        tick();
    endtask

    task automatic do_sc(input logic [TW-1:0] tid, input logic [AW-1:0] a, input logic exp);
        sc_valid = 1'b1; sc_tid = tid; sc_addr = a;
        exp_q.push_back(exp);
        tick();
    endtask

    task automatic check_state(input logic [TW-1:0] tid, input logic bit_e,
                               input logic [AW-1:0] addr_e, input logic [NT-1:0] vec_e);
        rd_tid  = tid;
        chk_stb = 1'b1;
        state_q.push_back({bit_e, addr_e, vec_e});
        tick();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [0:0]    e1;
        logic [SW-1:0] es;
        if (sc_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sc_success: unexpected SC, got %0b, nothing expected", sc_success);
            end else begin
                e1 = exp_q.pop_front();
                if (sc_success !== e1[0]) begin
                    bad++;
                    $display("FAIL sc_success @%0t: got %0b required %0b", $time, sc_success, e1[0]);
                end
            end
        end
        if (chk_stb) begin
            total++;
            if (state_q.size() == 0) begin
                bad++;
                $display("FAIL state: unexpected check, nothing expected");
            end else begin
                es = state_q.pop_front();
                if ({rd_llbit, rd_lladdr, resv_vec} !== es) begin
                    bad++;
                    $display("FAIL state @%0t tid=%0d: got llbit=%0b lladdr=%h vec=%b required llbit=%0b lladdr=%h vec=%b",
                             $time, rd_tid, rd_llbit, rd_lladdr, resv_vec,
                             es[SW-1], es[SW-2:NT], es[NT-1:0]);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        rd_tid = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check_state(0, 1'b0, 32'h0, 2'b00);
        check_state(1, 1'b0, 32'h0, 2'b00);

        // basic LL/SC, consumed reservation, retained address
        do_ll(0, 32'h1000_0004);
        do_sc(0, 32'h1000_0004, 1'b1);
        do_sc(0, 32'h1000_0004, 1'b0);
        check_state(0, 1'b0, 32'h1000_0004, 2'b00);

        // granule compare
        do_ll(1, 32'h2000_0008);
        check_state(1, 1'b1, 32'h2000_0008, 2'b10);
        do_sc(1, 32'h2000_000B, 1'b1);
        check_state(1, 1'b0, 32'h2000_0008, 2'b00);
        do_ll(1, 32'h2000_000B);
        do_sc(1, 32'h2000_000C, 1'b0);
        check_state(1, 1'b0, 32'h2000_0008, 2'b00);

        // successful SC breaks the other thread's link
        do_ll(0, 32'h3000_0000);
        do_ll(1, 32'h3000_0000);
        check_state(0, 1'b1, 32'h3000_0000, 2'b11);
        do_sc(0, 32'h3000_0000, 1'b1);
        check_state(1, 1'b0, 32'h3000_0000, 2'b00);
        do_sc(1, 32'h3000_0000, 1'b0);

        // same-cycle matching store beats the LL; non-matching store does not
        set_ll(0, 32'h4000_0010);
        st_valid = 1'b1; st_addr = 32'h4000_0010;
        tick();
        check_state(1, 1'b0, 32'h3000_0000, 2'b00);
        do_sc(0, 32'h4000_0010, 1'b0);
        set_ll(0, 32'h4000_0010);
        st_valid = 1'b1; st_addr = 32'h4000_0020;
        tick();
        check_state(0, 1'b1, 32'h4000_0010, 2'b01);
        do_sc(0, 32'h4000_0010, 1'b1);

        // a thread's own later store clears its link
        do_ll(0, 32'h5000_0000);
        st_valid = 1'b1; st_addr = 32'h5000_0002;
        tick();
        do_sc(0, 32'h5000_0000, 1'b0);

        // expiry after TIMEOUT edges
        do_ll(1, 32'h6000_0004);
        repeat (7) tick();
        check_state(1, 1'b1, 32'h6000_0004, 2'b10);
        check_state(1, 1'b0, 32'h6000_0004, 2'b00);
        do_sc(1, 32'h6000_0004, 1'b0);

        // per-thread clear
        do_ll(0, 32'h7000_0000);
        do_ll(1, 32'h7000_0040);
        clr_vec = 2'b10;
        tick();
        check_state(0, 1'b1, 32'h7000_0000, 2'b01);
        check_state(1, 1'b0, 32'h7000_0040, 2'b01);

        // asynchronous reset mid-cycle, checked before the next rising edge
        #1;
        rst_n   = 1'b0;
        rd_tid  = 0;
        chk_stb = 1'b1;
        state_q.push_back({1'b0, 32'h0, 2'b00});
        @(negedge clk);
        #1;
        chk_stb = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state(1, 1'b0, 32'h0, 2'b00);
        do_ll(1, 32'h8000_0000);
        do_sc(1, 32'h8000_0001, 1'b1);

        repeat (3) tick();
        total++;
        if (exp_q.size() != 0 || state_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0", exp_q.size(), state_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
